text_console_writer: RTL and testbench
======================================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 60, meaning text columns per row (480 px / 8 px glyph).
REQ-002 Parameter ROWS, default 17, meaning text rows per screen (272 px / 16 px glyph).
REQ-003 CLK  input  1  system clock; only clock, all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 char_valid  input  1  upstream character available.
REQ-006 char_data  input  8  ASCII character code.
REQ-007 char_ready  output  1  block accepts char_data this cycle.
REQ-008 clear_req  input  1  single-cycle request to blank the screen.
REQ-009 wen  output  1  text-buffer write strobe into the display controller.
REQ-010 waddr  output  16  text-buffer address, row*COLS+col.
REQ-011 wdata  output  8  character written to the text buffer.
REQ-012 busy  output  1  high while in CLEAR state.
REQ-013 cur_col  output  8  current cursor column.
REQ-014 cur_row  output  8  current cursor row.

Function
REQ-015 States SHALL be IDLE and CLEAR; char_ready SHALL be high only in IDLE, with clear_req low in that cycle.
REQ-016 A character SHALL be accepted on a cycle where char_valid and char_ready are both high; the resulting write SHALL appear on wen/waddr/wdata the following cycle, with wen high for exactly one cycle.
REQ-017 Printable codes 0x20-0x7E SHALL be written at the current cursor; the cursor then advances one column.
REQ-018 Advancing from col COLS-1 SHALL set col 0 and row+1; advancing from row ROWS-1 SHALL wrap to row 0 (no scrolling).
REQ-019 0x0A (LF) SHALL set col 0 and advance the row with the same wrap rule; no write is issued.
REQ-020 0x0D (CR) SHALL set col 0; no write is issued.
REQ-021 0x08 (BS) at col>0 SHALL decrement col and write 0x20 at the new position; at col 0 it SHALL be consumed with no effect.
REQ-022 0x0C (FF) SHALL enter CLEAR exactly as clear_req does.
REQ-023 All other codes (0x00-0x1F not listed above, and 0x7F-0xFF) SHALL be consumed with no write and no cursor change.
REQ-024 In IDLE, clear_req SHALL enter CLEAR on the next cycle; if char_valid is high in the same cycle, the character SHALL NOT be accepted.
REQ-025 CLEAR SHALL write 0x20 to addresses 0 through COLS*ROWS-1, one address per cycle, in ascending order, with wen high each cycle.
REQ-026 After the final CLEAR write, the block SHALL set the cursor to (0,0) and return to IDLE.
REQ-027 clear_req and char_valid SHALL be ignored while in CLEAR.
REQ-028 waddr arithmetic SHALL be 16-bit unsigned; COLS*ROWS SHALL NOT exceed 65536.

Reset
REQ-029 While RST is high, the block SHALL hold: state IDLE, wen 0, waddr 0, wdata 0, cur_col 0, cur_row 0, busy 0, char_ready 0.
REQ-030 RST asserted mid-CLEAR or mid-write SHALL abort the operation on that edge; no further write is issued for the aborted operation.

Configuration
REQ-031 Macro CONSOLE_CLEAR_ON_RESET_EN: when defined, the first cycle after RST deasserts SHALL enter CLEAR (a full blank of the screen, then cursor (0,0)). When not defined, the block SHALL enter IDLE with char_ready high and the buffer untouched.

Structure
REQ-032 Package console_pkg SHALL hold the default COLS/ROWS, the ASCII constants (BS, LF, FF, CR, SPACE) and the state encoding.
REQ-033 The cursor position and wrap logic SHALL live in sub-module console_cursor (inputs: advance, newline, home, back, zero; outputs: col, row, addr).

Verification
REQ-034 After reset, send 'A' (0x41) at (0,0) -> one cycle later wen=1, waddr=0, wdata=0x41; cursor becomes (1,0).
REQ-035 Send 60 printable characters, then 'Z' -> 'Z' is written at waddr=60 and the cursor becomes (1,1).
REQ-036 With the cursor at (0,16), send LF -> no wen; cursor becomes (0,0).
REQ-037 With the cursor at (5,2), send BS -> wen=1, waddr=124, wdata=0x20; cursor becomes (4,2). A BS at (0,2) -> no wen, cursor unchanged.
REQ-038 Assert clear_req together with char_valid -> the character is not accepted; exactly 1020 writes of 0x20 to addresses 0..1019 with busy=1 and char_ready=0; then cursor (0,0) and char_ready=1.
REQ-039 Assert RST at the 500th CLEAR write -> wen=0 from the next edge; with the macro undefined, IDLE follows with no further writes.

Source files
------------

// File: rtl/text_console_writer_pkg.sv
// Shared constants, state encoding and character classes for the text console writer.
package console_pkg;

  localparam int COLS_DEF = 60;
  localparam int ROWS_DEF = 17;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    C_PRINT,
    C_LF,
    C_CR,
    C_BS,
    C_FF,
    C_NONE
  } cls_t;

  function automatic cls_t classify(input logic [7:0] c);
    cls_t r;
    r = C_NONE;
    if (c >= 8'h20 && c <= 8'h7E) r = C_PRINT;
    else if (c == ASCII_LF)       r = C_LF;
    else if (c == ASCII_CR)       r = C_CR;
    else if (c == ASCII_BS)       r = C_BS;
    else if (c == ASCII_FF)       r = C_FF;
    return r;
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character input and text-buffer write bundle of the text console writer.
interface console_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        clear_req;
  logic        wen;
  logic [15:0] waddr;
  logic [7:0]  wdata;
  logic        busy;
  logic [7:0]  cur_col;
  logic [7:0]  cur_row;

  modport master (
    output char_valid, char_data, clear_req,
    input  char_ready, wen, waddr, wdata,
    input  busy, cur_col, cur_row
  );

  modport slave (
    input  char_valid, char_data, clear_req,
    output char_ready, wen, waddr, wdata,
    output busy, cur_col, cur_row
  );
endinterface

// File: rtl/text_console_writer_cursor.sv
// Cursor column/row with column and row wrap; exports row*COLS+col.
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        advance,
  input  logic        newline,
  input  logic        home,
  input  logic        back,
  input  logic        zero,
  output logic [7:0]  col,
  output logic [7:0]  row,
  output logic [15:0] addr
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  logic [7:0] r_col;
  logic [7:0] r_row;
  logic [7:0] w_row_inc;

  assign w_row_inc = (r_row == LAST_ROW) ? 8'd0 : r_row + 8'd1;

  always_ff @(posedge CLK) begin
    if (RST || zero) begin
      r_col <= 8'd0;
      r_row <= 8'd0;
    end else if (newline) begin
      r_col <= 8'd0;
      r_row <= w_row_inc;
    end else if (home) begin
      r_col <= 8'd0;
    end else if (back && r_col != 8'd0) begin
      r_col <= r_col - 8'd1;
    end else if (advance) begin
      if (r_col == LAST_COL) begin
        r_col <= 8'd0;
        r_row <= w_row_inc;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  assign col  = r_col;
  assign row  = r_row;
  assign addr = 16'(r_row) * 16'(COLS) + 16'(r_col);

endmodule

// File: rtl/text_console_writer.sv
// Streams ASCII into a display text buffer; screen blank via clear_req/FF.
// Optional: CONSOLE_CLEAR_ON_RESET_EN blanks the screen after reset.
module text_console_writer
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input logic     CLK,
  input logic     RST,
  console_if.slave bus
);

  localparam logic [15:0] LAST_ADDR = 16'(COLS * ROWS - 1);

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic        r_wen;
  logic [15:0] r_waddr;
  logic [7:0]  r_wdata;

  logic        w_ready, w_boot;
  logic        w_adv, w_nl, w_home, w_back, w_zero;
  logic        w_cwen;
  logic [15:0] w_caddr;
  logic [7:0]  w_cdata;
  logic [7:0]  w_col, w_row;
  logic [15:0] w_addr;
  cls_t        w_cls;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
  logic r_boot;
  always_ff @(posedge CLK) begin
    r_boot <= RST;
  end
  assign w_boot = r_boot;
`else
  assign w_boot = 1'b0;
`endif

  assign w_cls = classify(bus.char_data);

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .CLK     (CLK),
    .RST     (RST),
    .advance (w_adv),
    .newline (w_nl),
    .home    (w_home),
    .back    (w_back),
    .zero    (w_zero),
    .col     (w_col),
    .row     (w_row),
    .addr    (w_addr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_wen   <= 1'b0;
      r_waddr <= 16'd0;
      r_wdata <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_wen   <= w_cwen;
      if (w_cwen) begin
        r_waddr <= w_caddr;
        r_wdata <= w_cdata;
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ready   = 1'b0;
    w_adv     = 1'b0;
    w_nl      = 1'b0;
    w_home    = 1'b0;
    w_back    = 1'b0;
    w_zero    = 1'b0;
    w_cwen    = 1'b0;
    w_caddr   = w_addr;
    w_cdata   = bus.char_data;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_n = 16'd0;
        w_ready = !bus.clear_req && !w_boot && !RST;
        if (bus.clear_req || w_boot) begin
          w_state_n = ST_CLEAR;
        end else if (bus.char_valid && w_ready) begin
          unique case (1'b1)
            (w_cls == C_PRINT): begin
              w_cwen = 1'b1;
              w_adv  = 1'b1;
            end
            (w_cls == C_LF): w_nl   = 1'b1;
            (w_cls == C_CR): w_home = 1'b1;
            (w_cls == C_BS): begin
              // rub out the cell left of the cursor
              if (w_col != 8'd0) begin
                w_back  = 1'b1;
                w_cwen  = 1'b1;
                w_caddr = w_addr - 16'd1;
                w_cdata = ASCII_SPACE;
              end
            end
            (w_cls == C_FF): w_state_n = ST_CLEAR;
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        w_cnt_n = r_cnt + 16'd1;
        if (r_cnt == LAST_ADDR) begin
          w_state_n = ST_IDLE;
          w_zero    = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // clear writes are driven straight from the sweep counter
  assign bus.char_ready = w_ready;
  assign bus.busy       = (r_state == ST_CLEAR);
  assign bus.wen        = r_wen || (r_state == ST_CLEAR);
  assign bus.waddr      = (r_state == ST_CLEAR) ? r_cnt : r_waddr;
  assign bus.wdata      = (r_state == ST_CLEAR) ? ASCII_SPACE : r_wdata;
  assign bus.cur_col    = w_col;
  assign bus.cur_row    = w_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer (default build).
module tb_text_console_writer;
  import console_pkg::*;

  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam int NCELL = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  console_if bus ();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [7:0] c;
    int         col;
    int         row;
  } vec_t;

  wr_t sb[$];
  wr_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  int m_col = 0;
  int m_row = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input int a, input int d);
    wr_t w;
    w.a = 16'(a);
    w.d = 8'(d);
    sb.push_back(w);
  endfunction

  function automatic void row_next();
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
  endfunction

  function automatic void model(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(m_row * COLS + m_col, c);
      if (m_col == COLS - 1) begin
        m_col = 0;
        row_next();
      end else m_col++;
    end else if (c == 8'h0A) begin
      m_col = 0;
      row_next();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push(m_row * COLS + m_col, 8'h20);
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < NCELL; i++) push(i, 8'h20);
      m_col = 0;
      m_row = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (bus.wen === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected write: addr %0d data %0h expected none",
                 bus.waddr, bus.wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("waddr", 32'(bus.waddr), 32'(mon_e.a));
        chk("wdata", 32'(bus.wdata), 32'(mon_e.d));
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    bus.char_data  = c;
    bus.char_valid = 1'b1;
    while (bus.char_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.char_ready !== 1'b1) begin
      chk("ready timeout", 32'(bus.char_ready), 32'd1);
      bus.char_valid = 1'b0;
    end else begin
      model(c);
      @(posedge clk);
      @(negedge clk);
      bus.char_valid = 1'b0;
    end
  endtask

  task automatic chk_cur(input string nm, input int col, input int row);
    chk({nm, " col"}, 32'(bus.cur_col), 32'(col));
    chk({nm, " row"}, 32'(bus.cur_row), 32'(row));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_col = 0;
    m_row = 0;
    @(negedge clk);
  endtask

  vec_t tv[12];

  initial begin
    int busyc;
    int wc;
    tv = '{
      '{8'h41, 1, 0}, '{8'h42, 2, 0}, '{8'h0D, 0, 0}, '{8'h07, 0, 0},
      '{8'h7F, 0, 0}, '{8'h08, 0, 0}, '{8'h0A, 0, 1}, '{8'h78, 1, 1},
      '{8'h79, 2, 1}, '{8'h08, 1, 1}, '{8'hFF, 1, 1}, '{8'h00, 1, 1}
    };
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.clear_req  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst wen",   32'(bus.wen),        32'd0);
    chk("rst waddr", 32'(bus.waddr),      32'd0);
    chk("rst wdata", 32'(bus.wdata),      32'd0);
    chk("rst busy",  32'(bus.busy),       32'd0);
    chk("rst ready", 32'(bus.char_ready), 32'd0);
    chk_cur("rst", 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", 32'(bus.char_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(tv[i].c);
      chk_cur($sformatf("vec%0d", i), tv[i].col, tv[i].row);
    end

    do_reset();
    for (int i = 0; i < COLS; i++) send(8'(8'h30 + i % 10));
    chk_cur("row fill", 0, 1);
    send(8'h5A);
    chk_cur("Z", 1, 1);

    send(8'h0D);
    for (int i = 0; i < 15; i++) send(8'h0A);
    chk_cur("row16", 0, 16);
    send(8'h0A);
    chk_cur("lf wrap", 0, 0);
    chk("sb drained", 32'(sb.size()), 32'd0);

    send(8'h0A);
    send(8'h0A);
    repeat (5) send(8'h61);
    chk_cur("pre bs", 5, 2);
    send(8'h08);
    chk_cur("bs", 4, 2);
    send(8'h0D);
    send(8'h08);
    chk_cur("bs col0", 0, 2);

    send(8'h0C);
    send(8'h0D);
    chk_cur("ff clear", 0, 0);

    send(8'h0A);
    bus.char_data  = 8'h51;
    bus.char_valid = 1'b1;
    bus.clear_req  = 1'b1;
    #1;
    chk("ready w clear", 32'(bus.char_ready), 32'd0);
    for (int i = 0; i < NCELL; i++) push(i, 8'h20);
    @(negedge clk);
    bus.clear_req = 1'b0;
    busyc = 0;
    for (int k = 0; k < 1100; k++) begin
      if (bus.busy !== 1'b1) break;
      busyc++;
      if (bus.char_ready !== 1'b0)
        chk("ready in clear", 32'(bus.char_ready), 32'd0);
      bus.clear_req = (busyc == 100);
      @(negedge clk);
    end
    bus.char_valid = 1'b0;
    bus.clear_req  = 1'b0;
    m_col = 0;
    m_row = 0;
    chk("clear cycles", 32'(busyc), 32'(NCELL));
    chk_cur("after clear", 0, 0);
    chk("ready after clear", 32'(bus.char_ready), 32'd1);

    bus.clear_req = 1'b1;
    for (int i = 0; i < 500; i++) push(i, 8'h20);
    @(negedge clk);
    bus.clear_req = 1'b0;
    wc = 0;
    for (int k = 0; k < 1100; k++) begin
      if (bus.wen === 1'b1) wc++;
      if (wc == 500) break;
      @(negedge clk);
    end
    chk("writes before abort", 32'(wc), 32'd500);
    rst = 1'b1;
    @(negedge clk);
    chk("abort wen",   32'(bus.wen),        32'd0);
    chk("abort busy",  32'(bus.busy),       32'd0);
    chk("abort ready", 32'(bus.char_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_col = 0;
    m_row = 0;
    repeat (20) @(negedge clk);
    chk("idle after abort", 32'(bus.char_ready), 32'd1);
    chk("busy after abort", 32'(bus.busy),       32'd0);
    chk_cur("after abort", 0, 0);
    chk("sb empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
